// File: rtl/vesa_sync_gen_if.sv
// rtl/vesa_sync_gen_if.sv - output bundle of the VESA raster timing generator
// frame_cnt exists only when SYNC_GEN_FRAME_COUNT_EN is defined.
interface vesa_sync_gen_if #(
    parameter int CW = 11
);
    logic          h_sync;
    logic          v_sync;
    logic          de;
    logic          pf_active;
    logic [CW-1:0] pf_x;
    logic [CW-1:0] pf_y;
    logic [CW-1:0] y;
    logic          line_start;
    logic          frame_start;
`ifdef SYNC_GEN_FRAME_COUNT_EN
    logic [15:0]   frame_cnt;

    modport master (
        output h_sync, v_sync, de, pf_active, pf_x, pf_y, y,
               line_start, frame_start, frame_cnt
    );
    modport slave (
        input  h_sync, v_sync, de, pf_active, pf_x, pf_y, y,
               line_start, frame_start, frame_cnt
    );
`else
    modport master (
        output h_sync, v_sync, de, pf_active, pf_x, pf_y, y,
               line_start, frame_start
    );
    modport slave (
        input  h_sync, v_sync, de, pf_active, pf_x, pf_y, y,
               line_start, frame_start
    );
`endif
endinterface

// File: rtl/vesa_sync_gen.sv
// rtl/vesa_sync_gen.sv - parametrised VESA raster timing generator
// Optional frame counter enabled by SYNC_GEN_FRAME_COUNT_EN.
module vesa_sync_gen #(
    parameter int H_VISIBLE = 1280,
    parameter int H_FRONT   = 48,
    parameter int H_SYNC    = 112,
    parameter int H_BACK    = 248,
    parameter int V_VISIBLE = 1024,
    parameter int V_FRONT   = 1,
    parameter int V_SYNC    = 3,
    parameter int V_BACK    = 38,
    parameter int H_POL     = 1,
    parameter int V_POL     = 1,
    parameter int PREFETCH  = 2,
    parameter int CW        = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    vesa_sync_gen_if.master sync
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CW-1:0] C_ONE     = CW'(1);
    localparam logic [CW-1:0] C_H_VIS   = CW'(H_VISIBLE);
    localparam logic [CW-1:0] C_HS_BEG  = CW'(H_VISIBLE + H_FRONT);
    localparam logic [CW-1:0] C_HS_END  = CW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] C_H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] C_H_TOTAL = CW'(H_TOTAL);
    localparam logic [CW-1:0] C_V_VIS   = CW'(V_VISIBLE);
    localparam logic [CW-1:0] C_VS_BEG  = CW'(V_VISIBLE + V_FRONT);
    localparam logic [CW-1:0] C_VS_END  = CW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [CW-1:0] C_V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] C_PF      = CW'(PREFETCH);
    localparam logic [CW:0]   C_PF_X    = (CW+1)'(PREFETCH);
    localparam logic [CW:0]   C_H_TOT_X = (CW+1)'(H_TOTAL);
    localparam logic          C_HS_ON   = 1'(H_POL);
    localparam logic          C_VS_ON   = 1'(V_POL);

    logic [CW-1:0] r_h;
    logic [CW-1:0] r_v;
    logic          r_h_sync;
    logic          r_v_sync;
    logic          r_de;
    logic          r_pf_active;
    logic [CW-1:0] r_pf_x;
    logic [CW-1:0] r_pf_y;
    logic [CW-1:0] r_y;
    logic          r_line_start;
    logic          r_frame_start;

    logic          w_h_last;
    logic          w_v_last;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_vs_upd;
    logic [CW:0]   w_p_sum;
    logic          w_p_wrap;
    logic [CW-1:0] w_p_lo;
    logic [CW-1:0] w_v_next;
    logic [CW-1:0] w_pf_x;
    logic [CW-1:0] w_pf_y;
    logic          w_pf_act;

    assign w_h_last = (r_h == C_H_LAST);
    assign w_v_last = (r_v == C_V_LAST);
    assign w_hs_act = (r_h >= C_HS_BEG) && (r_h < C_HS_END);
    assign w_vs_act = (r_v >= C_VS_BEG) && (r_v < C_VS_END);
    assign w_vs_upd = (r_h == C_HS_BEG);
    assign w_v_next = w_v_last ? '0 : (r_v + C_ONE);

    // The wide sum only decides the wrap; the narrow sum may overflow CW bits,
    // but after subtracting H_TOTAL the result is exact modulo 2^CW.
    assign w_p_sum  = {1'b0, r_h} + C_PF_X;
    assign w_p_wrap = (w_p_sum >= C_H_TOT_X);
    assign w_p_lo   = r_h + C_PF;
    assign w_pf_x   = w_p_wrap ? (w_p_lo - C_H_TOTAL) : w_p_lo;
    assign w_pf_y   = w_p_wrap ? w_v_next : r_v;
    assign w_pf_act = (w_pf_x < C_H_VIS) && (w_pf_y < C_V_VIS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else begin
            r_h <= w_h_last ? '0 : (r_h + C_ONE);
            if (w_h_last) begin
                r_v <= w_v_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h_sync      <= ~C_HS_ON;
            r_v_sync      <= ~C_VS_ON;
            r_de          <= 1'b0;
            r_pf_active   <= 1'b0;
            r_pf_x        <= '0;
            r_pf_y        <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_h_sync      <= w_hs_act ? C_HS_ON : ~C_HS_ON;
            // v_sync edges are pinned to the h_sync leading edge.
            if (w_vs_upd) begin
                r_v_sync  <= w_vs_act ? C_VS_ON : ~C_VS_ON;
            end
            r_de          <= (r_h < C_H_VIS) && (r_v < C_V_VIS);
            r_pf_active   <= w_pf_act;
            r_pf_x        <= w_pf_x;
            r_pf_y        <= w_pf_y;
            r_y           <= r_v;
            r_line_start  <= (r_h == '0);
            r_frame_start <= (r_h == '0) && (r_v == '0);
        end
    end

    assign sync.h_sync      = r_h_sync;
    assign sync.v_sync      = r_v_sync;
    assign sync.de          = r_de;
    assign sync.pf_active   = r_pf_active;
    assign sync.pf_x        = r_pf_x;
    assign sync.pf_y        = r_pf_y;
    assign sync.y           = r_y;
    assign sync.line_start  = r_line_start;
    assign sync.frame_start = r_frame_start;

`ifdef SYNC_GEN_FRAME_COUNT_EN
    logic        r_first;
    logic [15:0] r_frame_cnt;

    // Counted alongside frame_start so the new value appears on the strobe clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_first     <= 1'b1;
            r_frame_cnt <= 16'd0;
        end else if ((r_h == '0) && (r_v == '0)) begin
            r_first <= 1'b0;
            if (!r_first) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign sync.frame_cnt = r_frame_cnt;
`endif
endmodule
